// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the 8-bit restoring divider.
// The optional divide-by-zero shortcut is controlled by the DIV_ZERO_CHECK_EN macro.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_WIDTH = 4;

  // Value of the step counter during the final CALC step.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/restore_sub9.sv
// 9-bit trial subtractor for one restoring-division step.
// borrow=1 means a < b, i.e. the trial remainder would be negative.
module restore_sub9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/restoring_divider.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, result held until Run drops.
// Define DIV_ZERO_CHECK_EN to short-circuit Divisor=0 straight to HOLD with DivZero set.
module restoring_divider
  import div_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [DIV_WIDTH-1:0] Dividend,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic [DIV_WIDTH-1:0] Quotient,
  output logic [DIV_WIDTH-1:0] Remainder,
  output logic                 Busy,
  output logic                 Done,
  output logic                 DivZero
);

  state_e               state_q;
  logic [DIV_WIDTH-1:0] q_q, r_q, d_q;
  logic [DIV_WIDTH-1:0] quot_q, rem_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q, done_q;
  logic [DIV_WIDTH-1:0] q_d, r_d;
  logic [DIV_WIDTH:0]   trial;
  logic                 borrow;
  logic                 unused_trial_msb;

  restore_sub9 u_sub (
    .a      ({r_q, q_q[DIV_WIDTH-1]}),
    .b      ({1'b0, d_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Partial remainder stays below the divisor, so a non-negative trial always fits in 8 bits.
  assign unused_trial_msb = trial[DIV_WIDTH];

  // NOTE: both outputs get a value on every path so no latch is inferred.
  always_comb begin
    q_d = {q_q[DIV_WIDTH-2:0], 1'b0};
    r_d = {r_q[DIV_WIDTH-2:0], q_q[DIV_WIDTH-1]};
    if (!borrow) begin
      q_d = {q_q[DIV_WIDTH-2:0], 1'b1};
      r_d = trial[DIV_WIDTH-1:0];
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q;
  assign DivZero = dz_q;
`else
  assign DivZero = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (Run) begin
`ifdef DIV_ZERO_CHECK_EN
            if (Divisor == '0) begin
              state_q <= HOLD;
              quot_q  <= '1;
              rem_q   <= Dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              dz_q    <= 1'b0;
`else
            begin
`endif
              state_q <= CALC;
              q_q     <= Dividend;
              d_q     <= Divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= HOLD;
            quot_q  <= q_d;
            rem_q   <= r_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        HOLD: begin
          // Waiting for Run to drop keeps a held-high Run from retriggering.
          if (!Run) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider; expectations follow the
// DIV_ZERO_CHECK_EN setting of the build.
module tb_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run = 1'b0;
  logic [7:0] Dividend = '0;
  logic [7:0] Divisor = '0;
  logic [7:0] Quotient, Remainder;
  logic       Busy, Done, DivZero;

  int tests = 0;
  int fails = 0;
  int edges;
  int busy_rises;
  int done_edge;
  logic prev_busy;
  logic busy_after_start;

  restoring_divider dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse Run for one start edge, optionally disturb operands/Run during CALC,
  // and wait (bounded) for Done. edges counts rising edges from start, inclusive.
  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs,
                        input bit tamper, output int n);
    @(negedge Clk);
    Dividend = dvd;
    Divisor  = dvs;
    Run      = 1'b1;
    @(posedge Clk);
    n = 1;
    @(negedge Clk);
    busy_after_start = Busy;
    Run = 1'b0;
    if (tamper) begin
      Dividend = 8'd1;
      Divisor  = 8'd1;
      Run      = 1'b1;
    end
    while (!Done && n < 20) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      check("busy_done_exclusive", int'(Busy & Done), 0);
    end
  endtask

  // Drop Run and confirm the FSM returns to IDLE with the result still visible.
  task automatic finish_op(input int exp_q, input int exp_r);
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("idle_done", Done, 0);
    check("idle_busy", Busy, 0);
    check("idle_quot_stable", Quotient, exp_q);
    check("idle_rem_stable", Remainder, exp_r);
  endtask

  initial begin
    // Reset state
    #2 Reset = 1'b1;
    #1;
    check("rst_quot", Quotient, 0);
    check("rst_rem", Remainder, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("no_start_without_run", Busy, 0);

    // 100 / 7 = 14 r 2
    run_op(8'd100, 8'd7, 1'b0, edges);
    check("d100_busy_at_start", busy_after_start, 1);
    check("d100_edges", edges, 9);
    check("d100_done", Done, 1);
    check("d100_quot", Quotient, 14);
    check("d100_rem", Remainder, 2);
    check("d100_divzero", DivZero, 0);
    finish_op(14, 2);

    // 200 / 0: shortcut or natural all-ones result depending on build
    run_op(8'd200, 8'd0, 1'b0, edges);
`ifdef DIV_ZERO_CHECK_EN
    check("dz_edges", edges, 1);
    check("dz_flag", DivZero, 1);
`else
    check("dz_edges", edges, 9);
    check("dz_flag", DivZero, 0);
`endif
    check("dz_quot", Quotient, 255);
    check("dz_rem", Remainder, 200);
    finish_op(255, 200);

    // 255 / 1 = 255 r 0; DivZero must be clear after a normal start
    run_op(8'd255, 8'd1, 1'b0, edges);
    check("d255_edges", edges, 9);
    check("d255_quot", Quotient, 255);
    check("d255_rem", Remainder, 0);
    check("d255_divzero", DivZero, 0);
    finish_op(255, 0);

    // 5 / 10 = 0 r 5
    run_op(8'd5, 8'd10, 1'b0, edges);
    check("d5_quot", Quotient, 0);
    check("d5_rem", Remainder, 5);
    finish_op(0, 5);

    // Run held high for 30 cycles: exactly one operation (77 / 5 = 15 r 2)
    @(negedge Clk);
    Dividend   = 8'd77;
    Divisor    = 8'd5;
    Run        = 1'b1;
    busy_rises = 0;
    done_edge  = 0;
    prev_busy  = Busy;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Busy && !prev_busy) busy_rises++;
      prev_busy = Busy;
      if (Done && done_edge == 0) done_edge = i;
    end
    check("hold_busy_rises", busy_rises, 1);
    check("hold_done_edge", done_edge, 9);
    check("hold_done_still", Done, 1);
    check("hold_quot", Quotient, 15);
    check("hold_rem", Remainder, 2);
    finish_op(15, 2);

    // Second operation after the held-Run one: 9 / 3 = 3 r 0
    run_op(8'd9, 8'd3, 1'b0, edges);
    check("d9_edges", edges, 9);
    check("d9_quot", Quotient, 3);
    check("d9_rem", Remainder, 0);
    finish_op(3, 0);

    // Operands and Run disturbed during CALC of 100 / 7
    run_op(8'd100, 8'd7, 1'b1, edges);
    check("tamper_edges", edges, 9);
    check("tamper_quot", Quotient, 14);
    check("tamper_rem", Remainder, 2);
    finish_op(14, 2);

    // Reset during CALC step 4 of 100 / 7
    @(negedge Clk);
    Dividend = 8'd100;
    Divisor  = 8'd7;
    Run      = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("midcalc_busy_before", Busy, 1);
    Reset = 1'b1;
    #1;
    check("midcalc_rst_quot", Quotient, 0);
    check("midcalc_rst_rem", Remainder, 0);
    check("midcalc_rst_busy", Busy, 0);
    check("midcalc_rst_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("post_rst_idle_busy", Busy, 0);
    check("post_rst_idle_quot", Quotient, 0);

    // 50 / 6 = 8 r 2
    run_op(8'd50, 8'd6, 1'b0, edges);
    check("d50_edges", edges, 9);
    check("d50_quot", Quotient, 8);
    check("d50_rem", Remainder, 2);
    finish_op(8, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
